ifetch_task_scheduler: RTL and testbench

//  Chooses which channel/thread the instruction fetch unit runs next, then starts it.
//  - Keeps a runnable flag and a saved resume PC for every task.
//  - Grants tasks round-robin and drives the fetch unit's next_task_* and jump_* inputs.
//  - Saves the resume PC when the running task suspends.
//  - Sits between channel wake-up sources and the instruction fetch unit.

---
 rtl/ifetch_task_scheduler.sv | 159 +++++++++++++++
 tb/tb_ifetch_task_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_task_scheduler.sv
// Round-robin task scheduler feeding the instruction fetch unit's next_task_*/jump_* inputs.
// Optional time-slice preemption is enabled by defining IFSCHED_TIMESLICE_EN.
module ifetch_task_scheduler #(
  parameter int unsigned CHAN_BITS   = 3,
  parameter int unsigned THREAD_BITS = 1,
  parameter int unsigned PC_BITS     = 12,
  parameter int unsigned QUANTUM     = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [(1 << (CHAN_BITS+THREAD_BITS))-1:0] task_wake,
  input  logic                                    task_suspend,
  input  logic [PC_BITS-1:0]                      suspend_pc,
  input  logic                                    suspend_keep,
  output logic [CHAN_BITS-1:0]                    next_task_channel,
  output logic [THREAD_BITS-1:0]                  next_task_thread,
  output logic                                    next_task_ready,
  output logic [PC_BITS-1:0]                      jump_target,
  output logic                                    jump_enable,
  output logic                                    preempt_req,
  output logic                                    busy
);

  localparam int unsigned IdxBits = CHAN_BITS + THREAD_BITS;
  localparam int unsigned NTask   = 1 << IdxBits;

  typedef enum logic [2:0] {StIdle, StSel, StRdy, StJmp, StRun} state_e;

  state_e               state_q, state_d;
  logic [NTask-1:0]     runnable_q, runnable_d;
  logic [PC_BITS-1:0]   pc_q [NTask];
  logic                 pc_we;
  logic [IdxBits-1:0]   grant_q, grant_d;
  logic [IdxBits-1:0]   rr_q, rr_d;
  logic [PC_BITS-1:0]   jt_q, jt_d;
  logic [IdxBits-1:0]   pick;
  logic                 pick_valid;

  // First runnable task strictly after rr_q; the last candidate wraps back to rr_q itself.
  always_comb begin
    logic [IdxBits-1:0] cand;
    cand       = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 1; i <= NTask; i++) begin
      cand = rr_q + IdxBits'(i);
      if (!pick_valid && runnable_q[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    runnable_d = runnable_q | task_wake;
    grant_d    = grant_q;
    rr_d       = rr_q;
    jt_d       = jt_q;
    pc_we      = 1'b0;
    case (state_q)
      StIdle: if (|runnable_q) state_d = StSel;
      StSel: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = StRdy;
        end else begin
          state_d = StIdle;
        end
      end
      StRdy: begin
        jt_d    = pc_q[grant_q];
        state_d = StJmp;
      end
      StJmp: begin
        rr_d    = grant_q;
        state_d = StRun;
      end
      StRun: begin
        if (task_suspend) begin
          pc_we               = 1'b1;
          runnable_d[grant_q] = suspend_keep | task_wake[grant_q];
          state_d             = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      runnable_q <= '0;
      grant_q    <= '0;
      rr_q       <= '0;
      jt_q       <= '0;
    end else begin
      state_q    <= state_d;
      runnable_q <= runnable_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      jt_q       <= jt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTask; i++) pc_q[i] <= '0;
    end else if (pc_we) begin
      pc_q[grant_q] <= suspend_pc;
    end
  end

  assign next_task_channel = grant_q[IdxBits-1:THREAD_BITS];
  assign next_task_thread  = grant_q[THREAD_BITS-1:0];
  assign next_task_ready   = (state_q == StRdy);
  assign jump_enable       = (state_q == StJmp);
  assign jump_target       = jt_q;
  assign busy              = (state_q == StRdy) || (state_q == StJmp) || (state_q == StRun);

`ifdef IFSCHED_TIMESLICE_EN
  localparam logic [15:0] QuantumLast = 16'(QUANTUM - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        preempt_q, preempt_d;
  logic        other_runnable;

  assign other_runnable = |(runnable_q & ~(NTask'(1) << grant_q));

  // Counter saturates at QuantumLast so preemption fires as soon as a competitor appears.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StJmp) begin
      cnt_d = '0;
    end else if ((state_q == StRun) && (cnt_q != QuantumLast)) begin
      cnt_d = cnt_q + 16'd1;
    end
    preempt_d = (state_q == StRun) && !task_suspend &&
                (preempt_q || ((cnt_q == QuantumLast) && other_runnable));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt_req = preempt_q;
`else
  logic unused_quantum;
  assign unused_quantum = ^QUANTUM;
  assign preempt_req    = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_task_scheduler.sv
// Directed bench for ifetch_task_scheduler: dispatch latency, PC save/restore, round-robin
// order, same-cycle wake/suspend, ignored suspend, mid-dispatch reset and optional time slicing.
module tb_ifetch_task_scheduler;

  logic        clk;
  logic        reset;
  logic [15:0] task_wake;
  logic        task_suspend;
  logic [11:0] suspend_pc;
  logic        suspend_keep;
  logic [2:0]  next_task_channel;
  logic [0:0]  next_task_thread;
  logic        next_task_ready;
  logic [11:0] jump_target;
  logic        jump_enable;
  logic        preempt_req;
  logic        busy;

  int errors = 0;
  int checks = 0;

  ifetch_task_scheduler #(
    .CHAN_BITS  (3),
    .THREAD_BITS(1),
    .PC_BITS    (12),
    .QUANTUM    (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .task_wake        (task_wake),
    .task_suspend     (task_suspend),
    .suspend_pc       (suspend_pc),
    .suspend_keep     (suspend_keep),
    .next_task_channel(next_task_channel),
    .next_task_thread (next_task_thread),
    .next_task_ready  (next_task_ready),
    .jump_target      (jump_target),
    .jump_enable      (jump_enable),
    .preempt_req      (preempt_req),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_wake(input logic [15:0] w);
    task_wake = w;
    tick();
    task_wake = '0;
  endtask

  // Starts in IDLE with the flags already set; ends in the first RUN cycle.
  task automatic dispatch(input int idx, input logic [11:0] pc);
    tick();
    chk("sel_ready_low", 32'(next_task_ready), 32'd0);
    tick();
    chk("rdy_ready", 32'(next_task_ready), 32'd1);
    chk("rdy_idx", 32'({next_task_channel, next_task_thread}), 32'(idx));
    chk("rdy_busy", 32'(busy), 32'd1);
    tick();
    chk("jmp_enable", 32'(jump_enable), 32'd1);
    chk("jmp_target", 32'(jump_target), 32'(pc));
    chk("jmp_ready_low", 32'(next_task_ready), 32'd0);
    tick();
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_enable_low", 32'(jump_enable), 32'd0);
  endtask

  task automatic do_suspend(input logic [11:0] pc, input logic keep, input logic [15:0] w);
    task_suspend = 1'b1;
    suspend_pc   = pc;
    suspend_keep = keep;
    task_wake    = w;
    tick();
    task_suspend = 1'b0;
    suspend_keep = 1'b0;
    task_wake    = '0;
    chk("susp_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    task_wake    = '0;
    task_suspend = 1'b0;
    suspend_pc   = '0;
    suspend_keep = 1'b0;
    #12;
    chk("rst_ready", 32'(next_task_ready), 32'd0);
    chk("rst_enable", 32'(jump_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_preempt", 32'(preempt_req), 32'd0);
    chk("rst_outs", 32'({next_task_channel, next_task_thread, jump_target}), 32'd0);
    reset = 1'b1;
    tick();

    // Wake ch3/th0 and dispatch with the reset PC.
    pulse_wake(16'h0040);
    chk("wake_not_busy", 32'(busy), 32'd0);
    dispatch(6, 12'h000);

    // Voluntary stop: no redispatch until a new wake, then resume at saved PC.
    do_suspend(12'h045, 1'b0, 16'h0000);
    tick();
    tick();
    chk("idle_no_ready", 32'(next_task_ready), 32'd0);
    chk("hold_channel", 32'(next_task_channel), 32'd3);
    pulse_wake(16'h0040);
    dispatch(6, 12'h045);

    // Build flags {1,4,6} with rr_ptr=4, then check order 6,1,4,6.
    do_suspend(12'h100, 1'b0, 16'h0000);
    pulse_wake(16'h0010);
    dispatch(4, 12'h000);
    pulse_wake(16'h0042);
    do_suspend(12'h044, 1'b1, 16'h0000);
    dispatch(6, 12'h100);
    do_suspend(12'h066, 1'b1, 16'h0000);
    dispatch(1, 12'h000);
    do_suspend(12'h011, 1'b1, 16'h0000);
    dispatch(4, 12'h044);
    do_suspend(12'h444, 1'b1, 16'h0000);
    dispatch(6, 12'h066);

    // Same-cycle wake and suspend keeps task 6 runnable; drain the others.
    do_suspend(12'h0AA, 1'b0, 16'h0040);
    dispatch(1, 12'h011);
    do_suspend(12'h0B1, 1'b0, 16'h0000);
    dispatch(4, 12'h444);
    do_suspend(12'h0B4, 1'b0, 16'h0000);
    dispatch(6, 12'h0AA);
    // Sole runnable task wraps back to itself.
    do_suspend(12'h0C6, 1'b1, 16'h0000);
    dispatch(6, 12'h0C6);
    do_suspend(12'h0D6, 1'b0, 16'h0000);

    // Suspend outside RUN must be ignored.
    task_suspend = 1'b1;
    suspend_pc   = 12'hFFF;
    suspend_keep = 1'b1;
    tick();
    task_suspend = 1'b0;
    suspend_keep = 1'b0;
    tick();
    tick();
    tick();
    chk("bad_susp_ready", 32'(next_task_ready), 32'd0);
    chk("bad_susp_busy", 32'(busy), 32'd0);
    pulse_wake(16'h0040);
    dispatch(6, 12'h0D6);

    // Reset during JMP aborts the pulse and clears flags and PCs.
    do_suspend(12'h0E6, 1'b1, 16'h0000);
    tick();
    tick();
    tick();
    chk("pre_rst_enable", 32'(jump_enable), 32'd1);
    chk("pre_rst_target", 32'(jump_target), 32'h0E6);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_enable", 32'(jump_enable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_target", 32'(jump_target), 32'd0);
    #3;
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_ready", 32'(next_task_ready), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    pulse_wake(16'h0040);
    dispatch(6, 12'h000);

`ifdef IFSCHED_TIMESLICE_EN
    // Tasks 2 and 5 runnable, QUANTUM=8: preempt after 8 RUN cycles.
    do_suspend(12'h000, 1'b0, 16'h0000);
    pulse_wake(16'h0024);
    dispatch(2, 12'h000);
    repeat (7) tick();
    chk("ts_no_preempt", 32'(preempt_req), 32'd0);
    tick();
    chk("ts_preempt", 32'(preempt_req), 32'd1);
    tick();
    chk("ts_preempt_hold", 32'(preempt_req), 32'd1);
    do_suspend(12'h022, 1'b1, 16'h0000);
    chk("ts_preempt_clr", 32'(preempt_req), 32'd0);
    dispatch(5, 12'h000);
    do_suspend(12'h055, 1'b0, 16'h0000);
    dispatch(2, 12'h022);
`else
    repeat (10) tick();
    chk("no_ts_preempt", 32'(preempt_req), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
